sparse_pos_pack: RTL and testbench



---
 rtl/sparse_pos_pack.sv | 193 +++++++++++++++++++
 tb/tb_sparse_pos_pack.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_pos_pack.sv
// Packs nonzero ternary coefficients as {pos, sign} entries, CORE_NUM per word, into the position memory.
// Latency: a completed word is written one cycle after its last entry; no backpressure on the write port.
module sparse_pos_pack #(
    parameter int POLY_LEN      = 512,
    parameter int CORE_NUM      = 4,
    parameter int SPARSE_NUM    = 256,
    parameter int POS_WIDTH     = $clog2(POLY_LEN),
    parameter int POS_MEM_DEPTH = (SPARSE_NUM + CORE_NUM - 1) / CORE_NUM,
    parameter int POS_MEM_WIDTH = (POS_WIDTH + 1) * CORE_NUM
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               coef_valid,
    input  logic [1:0]                         coef_in,
    output logic                               coef_ready,
    output logic                               mem_pos_wren,
    output logic [$clog2(POS_MEM_DEPTH)-1:0]   mem_pos_wr_addr,
    output logic [POS_MEM_WIDTH-1:0]           mem_pos_din,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output logic [$clog2(POLY_LEN+1)-1:0]      nz_count
);

    localparam int EW  = POS_WIDTH + 1;
    localparam int AW  = $clog2(POS_MEM_DEPTH);
    localparam int CW  = AW + 1;
    localparam int NZW = $clog2(POLY_LEN + 1);
    localparam int FW  = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;

    localparam logic [POS_WIDTH-1:0] LAST_IDX  = POS_WIDTH'(POLY_LEN - 1);
    localparam logic [NZW-1:0]       SPARSE_C  = NZW'(SPARSE_NUM);
    localparam logic [CW-1:0]        DEPTH_C   = CW'(POS_MEM_DEPTH);
    localparam logic [CW-1:0]        LAST_ADDR = CW'(POS_MEM_DEPTH - 1);
    localparam logic [FW-1:0]        FILL_LAST = FW'(CORE_NUM - 1);

    typedef enum logic [2:0] {IDLE, SCAN, FLUSH, ZFILL, DONE} state_t;

    state_t                   state_q, state_d;
    logic [POS_WIDTH-1:0]     idx_q, idx_d;
    logic [NZW-1:0]           nz_q, nz_d;
    logic [POS_MEM_WIDTH-1:0] pack_q, pack_d;
    logic [FW-1:0]            fill_q, fill_d;
    logic [CW-1:0]            wcnt_q, wcnt_d;
    logic                     err_q, err_d;
    logic                     wren_q, wren_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic [POS_MEM_WIDTH-1:0] din_q, din_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic                     rdy_q, rdy_d;
    logic [EW-1:0]            entry;
    logic [POS_MEM_WIDTH-1:0] word;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nz_d    = nz_q;
        pack_d  = pack_q;
        fill_d  = fill_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        wren_d  = 1'b0;
        addr_d  = addr_q;
        din_d   = '0;
        done_d  = 1'b0;
        // sign bit is 1 for +1 (2'b01) and 0 for -1 (2'b11)
        entry   = {idx_q, ~coef_in[1]};
        word    = pack_q;
        for (int k = 0; k < CORE_NUM; k++) begin
            if (fill_q == FW'(k)) begin
                word[k*EW +: EW] = entry;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    nz_d    = '0;
                    pack_d  = '0;
                    fill_d  = '0;
                    wcnt_d  = '0;
                    err_d   = 1'b0;
                end
            end
            SCAN: begin
                if (coef_valid) begin
                    idx_d = idx_q + 1'b1;
                    if (coef_in == 2'b10) begin
                        err_d = 1'b1;
                    end else if (coef_in != 2'b00) begin
                        nz_d = nz_q + 1'b1;
                        if (nz_q >= SPARSE_C) begin
                            err_d = 1'b1;
                        end else if (fill_q == FILL_LAST) begin
                            wren_d = 1'b1;
                            addr_d = wcnt_q[AW-1:0];
                            din_d  = word;
                            wcnt_d = wcnt_q + 1'b1;
                            pack_d = '0;
                            fill_d = '0;
                        end else begin
                            pack_d = word;
                            fill_d = fill_q + 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (fill_q != '0 && wcnt_q < DEPTH_C) begin
                    wren_d = 1'b1;
                    addr_d = wcnt_q[AW-1:0];
                    din_d  = pack_q;
                    wcnt_d = wcnt_q + 1'b1;
                end
                pack_d  = '0;
                fill_d  = '0;
                state_d = ZFILL;
            end
            ZFILL: begin
                if (wcnt_q < DEPTH_C) begin
                    wren_d = 1'b1;
                    addr_d = wcnt_q[AW-1:0];
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == LAST_ADDR) begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (nz_q != SPARSE_C) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        rdy_d  = (state_d == SCAN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            nz_q    <= '0;
            pack_q  <= '0;
            fill_q  <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nz_q    <= nz_d;
            pack_q  <= pack_d;
            fill_q  <= fill_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    assign coef_ready      = rdy_q;
    assign mem_pos_wren    = wren_q;
    assign mem_pos_wr_addr = addr_q;
    assign mem_pos_din     = din_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign nz_count        = nz_q;

endmodule

// File: tb/tb_sparse_pos_pack.sv
// Directed bench for sparse_pos_pack: pack format, nominal, overflow, underflow, stall/illegal code, reset abort.
module tb_sparse_pos_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        coef_valid;
    logic [1:0]  coef_in;
    logic        coef_ready;
    logic        mem_pos_wren;
    logic [5:0]  mem_pos_wr_addr;
    logic [39:0] mem_pos_din;
    logic        busy;
    logic        done;
    logic        err;
    logic [9:0]  nz_count;

    sparse_pos_pack dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .coef_valid      (coef_valid),
        .coef_in         (coef_in),
        .coef_ready      (coef_ready),
        .mem_pos_wren    (mem_pos_wren),
        .mem_pos_wr_addr (mem_pos_wr_addr),
        .mem_pos_din     (mem_pos_din),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .nz_count        (nz_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write/done monitor, sampled on the falling edge.
    logic [5:0]  log_addr [1024];
    logic [39:0] log_dat  [1024];
    int n_wr   = 0;
    int n_done = 0;

    always @(negedge clk) begin
        if (mem_pos_wren === 1'b1) begin
            if (n_wr < 1024) begin
                log_addr[n_wr] <= mem_pos_wr_addr;
                log_dat[n_wr]  <= mem_pos_din;
            end
            n_wr <= n_wr + 1;
        end
        if (done === 1'b1) begin
            n_done <= n_done + 1;
        end
    end

    logic [1:0] coefs [512];
    int run_base;
    int run_done0;

    function automatic logic [39:0] pack4(input int e0, input int e1, input int e2, input int e3);
        logic [39:0] w;
        w = (40'(e3) << 30) | (40'(e2) << 20) | (40'(e1) << 10) | 40'(e0);
        return w;
    endfunction

    // Nominal pattern: +1 at even, -1 at odd positions; entry = 2*pos + sign.
    function automatic logic [39:0] nominal_word(input int k);
        int p;
        p = 4 * k;
        return pack4(2*p + 1, 2*(p+1), 2*(p+2) + 1, 2*(p+3));
    endfunction

    task automatic clear_coefs();
        for (int i = 0; i < 512; i++) coefs[i] = 2'b00;
    endtask

    task automatic set_nominal();
        clear_coefs();
        for (int i = 0; i < 256; i++) coefs[i] = (i % 2 == 0) ? 2'b01 : 2'b11;
    endtask

    task automatic run(input bit gaps, input int start_at, input int abort_at);
        int  i;
        int  cyc;
        bit  v;
        bit  acc;
        run_base  = n_wr;
        run_done0 = n_done;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("ready_after_start", 64'(coef_ready), 64'd1);
        chk("err_cleared_by_start", 64'(err), 64'd0);
        i   = 0;
        cyc = 0;
        while (i < 512 && cyc < 20000) begin
            if (i == abort_at) begin
                rst        = 1'b0;
                coef_valid = 1'b0;
                start      = 1'b0;
                return;
            end
            v          = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            coef_valid = v;
            coef_in    = coefs[i];
            start      = (i == start_at);
            acc        = v && coef_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) i++;
        end
        coef_valid = 1'b0;
        coef_in    = 2'b00;
        start      = 1'b0;
        chk("scan_complete", 64'(i), 64'd512);
        for (int c = 0; c < 400 && n_done == run_done0; c++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("done_pulses", 64'(n_done - run_done0), 64'd1);
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic check_writes(input string tag);
        int bad;
        bad = 0;
        chk({tag, "_wr_count"}, 64'(n_wr - run_base), 64'd64);
        for (int k = 0; k < 64; k++) begin
            if (log_addr[run_base + k] != 6'(k)) bad++;
        end
        chk({tag, "_addr_order"}, 64'(bad), 64'd0);
    endtask

    function automatic int zero_words_bad(input int from);
        int bad;
        bad = 0;
        for (int k = from; k < 64; k++) begin
            if (log_dat[run_base + k] != 40'd0) bad++;
        end
        return bad;
    endfunction

    function automatic int nominal_bad();
        int bad;
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            if (log_dat[run_base + k] != nominal_word(k)) bad++;
        end
        return bad;
    endfunction

    initial begin
        int saved;
        rst        = 1'b0;
        start      = 1'b0;
        coef_valid = 1'b0;
        coef_in    = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(coef_ready), 64'd0);
        chk("rst_wren", 64'(mem_pos_wren), 64'd0);
        chk("rst_addr", 64'(mem_pos_wr_addr), 64'd0);
        chk("rst_din", 64'(mem_pos_din), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_nz", 64'(nz_count), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Nominal run with a stray start pulse mid-scan.
        set_nominal();
        run(1'b0, 100, -1);
        check_writes("nom");
        chk("nom_word0", 64'(log_dat[run_base]), 64'(pack4(1, 2, 5, 6)));
        chk("nom_word63", 64'(log_dat[run_base + 63]), 64'(pack4(505, 506, 509, 510)));
        chk("nom_all_words", 64'(nominal_bad()), 64'd0);
        chk("nom_err", 64'(err), 64'd0);
        chk("nom_nz", 64'(nz_count), 64'd256);

        // Overflow: 300 nonzeros.
        clear_coefs();
        for (int i = 0; i < 300; i++) coefs[i] = 2'b01;
        run(1'b0, -1, -1);
        check_writes("ovf");
        chk("ovf_last_word", 64'(log_dat[run_base + 63]), 64'(pack4(505, 507, 509, 511)));
        chk("ovf_err", 64'(err), 64'd1);
        chk("ovf_nz", 64'(nz_count), 64'd300);

        // Underflow: 5 nonzeros.
        clear_coefs();
        coefs[10] = 2'b01;
        coefs[20] = 2'b11;
        coefs[30] = 2'b01;
        coefs[40] = 2'b11;
        coefs[50] = 2'b01;
        run(1'b0, -1, -1);
        check_writes("unf");
        chk("unf_word0", 64'(log_dat[run_base]), 64'(pack4(21, 40, 61, 80)));
        chk("unf_word1", 64'(log_dat[run_base + 1]), 64'(pack4(101, 0, 0, 0)));
        chk("unf_zero_fill", 64'(zero_words_bad(2)), 64'd0);
        chk("unf_err", 64'(err), 64'd1);
        chk("unf_nz", 64'(nz_count), 64'd5);

        // Random valid gaps plus one illegal code in the zero region.
        set_nominal();
        coefs[300] = 2'b10;
        run(1'b1, -1, -1);
        check_writes("stl");
        chk("stl_all_words", 64'(nominal_bad()), 64'd0);
        chk("stl_err", 64'(err), 64'd1);
        chk("stl_nz", 64'(nz_count), 64'd256);

        // Reset dropped at index 200.
        set_nominal();
        run(1'b0, -1, 200);
        @(negedge clk);
        chk("abort_ready", 64'(coef_ready), 64'd0);
        chk("abort_wren", 64'(mem_pos_wren), 64'd0);
        chk("abort_addr", 64'(mem_pos_wr_addr), 64'd0);
        chk("abort_din", 64'(mem_pos_din), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_err", 64'(err), 64'd0);
        chk("abort_nz", 64'(nz_count), 64'd0);
        saved = n_wr;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_writes", 64'(n_wr - saved), 64'd0);
        rst = 1'b1;

        // Clean run after reset: pack format.
        clear_coefs();
        coefs[3]   = 2'b01;
        coefs[7]   = 2'b11;
        coefs[8]   = 2'b01;
        coefs[511] = 2'b11;
        run(1'b0, -1, -1);
        check_writes("fmt");
        chk("fmt_word0", 64'(log_dat[run_base]), 64'(pack4(7, 14, 17, 1022)));
        chk("fmt_zero_fill", 64'(zero_words_bad(1)), 64'd0);
        chk("fmt_err", 64'(err), 64'd1);
        chk("fmt_nz", 64'(nz_count), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
